// File: rtl/timer_responder.sv
// Memory-mapped countdown timer that responds on the CPU memory bus.
// Four word registers (CTRL, LOAD, COUNT, STATUS), prescaled tick, interrupt on expiry.
module timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output tri   [31:0] rdata,
  input  logic        mem_rd,
  input  logic        mem_wr,
  output logic        hwint
);

  localparam logic [15:0] PSC_MAX = 16'(PRESCALE - 1);

  logic        en_q, en_d;
  logic        reload_q, reload_d;
  logic        ie_q, ie_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        exp_q, exp_d;
  logic [15:0] psc_q, psc_d;
  logic        hwint_q;

  logic        hit_s;
  logic        ctrl_wr_s, load_wr_s, count_wr_s, status_wr_s;
  logic        tick_s;
  logic        expire_s;
  logic [31:0] rd_val_s;

  assign hit_s       = (addr[31:2] == BASE_ADDR[31:2]);
  assign ctrl_wr_s   = mem_wr && hit_s && (addr[1:0] == 2'd0);
  assign load_wr_s   = mem_wr && hit_s && (addr[1:0] == 2'd1);
  assign count_wr_s  = mem_wr && hit_s && (addr[1:0] == 2'd2);
  assign status_wr_s = mem_wr && hit_s && (addr[1:0] == 2'd3);
  assign tick_s      = en_q && (psc_q == PSC_MAX);

  always_comb begin
    case (addr[1:0])
      2'd0:    rd_val_s = {29'd0, ie_q, reload_q, en_q};
      2'd1:    rd_val_s = load_q;
      2'd2:    rd_val_s = count_q;
      2'd3:    rd_val_s = {31'd0, exp_q};
      default: rd_val_s = 32'd0;
    endcase
  end

  assign rdata = (mem_rd && hit_s) ? rd_val_s : 32'bz;
  assign hwint = hwint_q;

  // Bus writes take priority over the hardware count/reload/clear of the same cycle.
  always_comb begin
    en_d     = en_q;
    reload_d = reload_q;
    ie_d     = ie_q;
    count_d  = count_q;
    exp_d    = exp_q;
    expire_s = 1'b0;
    load_d   = load_wr_s ? wdata : load_q;

    if (!en_q || tick_s || ctrl_wr_s) begin
      psc_d = 16'd0;
    end else begin
      psc_d = psc_q + 16'd1;
    end

    if (tick_s && !count_wr_s) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else if (count_q == 32'd1) begin
        expire_s = 1'b1;
        if (reload_q) begin
          count_d = load_d;
        end else begin
          count_d = 32'd0;
          en_d    = 1'b0;
        end
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end

    if (count_wr_s) begin
      count_d = wdata;
    end else begin
      count_d = count_d;
    end

    if (ctrl_wr_s) begin
      en_d     = wdata[0];
      reload_d = wdata[1];
      ie_d     = wdata[2];
    end else begin
      ie_d = ie_q;
    end

    // Expiry wins over a simultaneous write-1-to-clear.
    if (expire_s) begin
      exp_d = 1'b1;
    end else if (status_wr_s && wdata[0]) begin
      exp_d = 1'b0;
    end else begin
      exp_d = exp_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      ie_q     <= 1'b0;
      load_q   <= 32'd0;
      count_q  <= 32'd0;
      exp_q    <= 1'b0;
      psc_q    <= 16'd0;
      hwint_q  <= 1'b0;
    end else begin
      en_q     <= en_d;
      reload_q <= reload_d;
      ie_q     <= ie_d;
      load_q   <= load_d;
      count_q  <= count_d;
      exp_q    <= exp_d;
      psc_q    <= psc_d;
      hwint_q  <= exp_d && ie_d;
    end
  end

endmodule

// File: tb/tb_timer_responder.sv
// Directed bench for timer_responder: one DUT with PRESCALE=1, one with PRESCALE=3, sharing the bus.
module tb_timer_responder;

  localparam logic [31:0] A_CTRL   = 32'hFFFF_FF00;
  localparam logic [31:0] A_LOAD   = 32'hFFFF_FF01;
  localparam logic [31:0] A_COUNT  = 32'hFFFF_FF02;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FF03;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_rd;
  logic        mem_wr;
  wire  [31:0] rdata1;
  wire  [31:0] rdata3;
  logic        hwint1;
  logic        hwint3;
  logic [31:0] r1;
  logic [31:0] r3;
  int          checks = 0;
  int          failures = 0;

  timer_responder #(.BASE_ADDR(32'hFFFF_FF00), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rdata(rdata1),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .hwint(hwint1)
  );

  timer_responder #(.BASE_ADDR(32'hFFFF_FF00), .PRESCALE(3)) u3 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rdata(rdata3),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .hwint(hwint3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    wdata  = d;
    mem_wr = 1'b1;
    @(posedge clk);
    #1;
    mem_wr = 1'b0;
    addr   = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a);
    addr   = a;
    mem_rd = 1'b1;
    #1;
    r1     = rdata1;
    r3     = rdata3;
    mem_rd = 1'b0;
    addr   = 32'd0;
  endtask

  initial begin
    rst    = 1'b1;
    addr   = 32'd0;
    wdata  = 32'd0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    rd(A_CTRL);   chk("rst_ctrl", r1, 32'd0);
    rd(A_LOAD);   chk("rst_load", r1, 32'd0);
    rd(A_COUNT);  chk("rst_count", r1, 32'd0);
    rd(A_STATUS); chk("rst_status", r1, 32'd0);
    chk("rst_hwint", {31'd0, hwint1}, 32'd0);

    // Non-hit accesses
    addr = 32'h0000_0010; mem_rd = 1'b1; #1;
    checks++;
    assert (rdata1 === 32'bz) else begin
      failures++;
      $error("FAIL nohit_rd_z observed=%h expected=zzzzzzzz", rdata1);
    end
    mem_rd = 1'b0;
    wr(32'h0000_0011, 32'd5);
    rd(A_LOAD); chk("nohit_wr_ignored", r1, 32'd0);

    // Asynchronous reset mid-count
    wr(A_COUNT, 32'd5);
    wr(A_CTRL, 32'd1);
    step();
    rd(A_COUNT); chk("midcount_before_rst", r1, 32'd4);
    rst = 1'b1; #1;
    rd(A_COUNT); chk("midrst_count", r1, 32'd0);
    rd(A_CTRL);  chk("midrst_ctrl", r1, 32'd0);
    chk("midrst_hwint", {31'd0, hwint1}, 32'd0);
    rst = 1'b0;
    rd(A_COUNT); chk("midrst_count_hold", r1, 32'd0);

    // One-shot, PRESCALE=1
    wr(A_COUNT, 32'd3);
    wr(A_CTRL, 32'd5);
    rd(A_COUNT); chk("os_e0_count", r1, 32'd3);
    step(); rd(A_COUNT); chk("os_e1_count", r1, 32'd2);
    chk("os_e1_hwint", {31'd0, hwint1}, 32'd0);
    step(); rd(A_STATUS); chk("os_e2_status", r1, 32'd0);
    chk("os_e2_hwint", {31'd0, hwint1}, 32'd0);
    step();
    chk("os_e3_hwint", {31'd0, hwint1}, 32'd1);
    rd(A_STATUS); chk("os_e3_status", r1, 32'd1);
    rd(A_COUNT);  chk("os_e3_count", r1, 32'd0);
    rd(A_CTRL);   chk("os_e3_ctrl", r1, 32'h4);
    wr(A_STATUS, 32'd1);
    chk("os_clr_hwint", {31'd0, hwint1}, 32'd0);
    rd(A_STATUS); chk("os_clr_status", r1, 32'd0);

    // Auto-reload, period 4
    wr(A_LOAD, 32'd4);
    wr(A_COUNT, 32'd4);
    wr(A_CTRL, 32'd7);
    rd(A_COUNT); chk("ar_e0_count", r1, 32'd4);
    step(); rd(A_COUNT); chk("ar_e1_count", r1, 32'd3);
    step(); rd(A_COUNT); chk("ar_e2_count", r1, 32'd2);
    step(); rd(A_COUNT); chk("ar_e3_count", r1, 32'd1);
    chk("ar_e3_hwint", {31'd0, hwint1}, 32'd0);
    step(); rd(A_COUNT); chk("ar_e4_count", r1, 32'd4);
    chk("ar_e4_hwint", {31'd0, hwint1}, 32'd1);
    wr(A_STATUS, 32'd1);
    rd(A_COUNT); chk("ar_e5_count", r1, 32'd3);
    chk("ar_e5_hwint", {31'd0, hwint1}, 32'd0);
    step(); chk("ar_e6_hwint", {31'd0, hwint1}, 32'd0);
    step(); chk("ar_e7_hwint", {31'd0, hwint1}, 32'd0);
    step(); chk("ar_e8_hwint", {31'd0, hwint1}, 32'd1);
    rd(A_COUNT); chk("ar_e8_count", r1, 32'd4);

    // Collision: STATUS clear on the expiry edge
    wr(A_STATUS, 32'd1);
    chk("col_pre_hwint", {31'd0, hwint1}, 32'd0);
    step();
    step(); rd(A_COUNT); chk("col_e11_count", r1, 32'd1);
    wr(A_STATUS, 32'd1);
    rd(A_STATUS); chk("col_setwins_status", r1, 32'd1);
    chk("col_setwins_hwint", {31'd0, hwint1}, 32'd1);
    rd(A_COUNT); chk("col_setwins_count", r1, 32'd4);

    // Collision: COUNT write on the edge that would expire
    wr(A_CTRL, 32'd5);
    rd(A_COUNT); chk("cw_e13_count", r1, 32'd3);
    wr(A_STATUS, 32'd1);
    step(); rd(A_COUNT); chk("cw_e15_count", r1, 32'd1);
    wr(A_COUNT, 32'd9);
    rd(A_COUNT);  chk("cw_count", r1, 32'd9);
    rd(A_STATUS); chk("cw_status", r1, 32'd0);
    rd(A_CTRL);   chk("cw_ctrl", r1, 32'd5);
    step(); rd(A_COUNT); chk("cw_next_count", r1, 32'd8);
    wr(A_CTRL, 32'd0);

    // Read and write in the same cycle
    wr(A_LOAD, 32'd7);
    addr = A_LOAD; wdata = 32'hAB; mem_rd = 1'b1; mem_wr = 1'b1; #1;
    r1 = rdata1;
    chk("rw_pre_edge", r1, 32'd7);
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
    rd(A_LOAD); chk("rw_after", r1, 32'hAB);

    // Prescaler on the PRESCALE=3 instance, IE=0
    rst = 1'b1; #1; rst = 1'b0;
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'd1);
    step(); rd(A_COUNT); chk("ps_e1_count", r3, 32'd2);
    step(); rd(A_COUNT); chk("ps_e2_count", r3, 32'd2);
    step(); rd(A_COUNT); chk("ps_e3_count", r3, 32'd1);
    step(); rd(A_COUNT); chk("ps_e4_count", r3, 32'd1);
    step(); rd(A_COUNT); chk("ps_e5_count", r3, 32'd1);
    rd(A_STATUS); chk("ps_e5_status", r3, 32'd0);
    step(); rd(A_COUNT); chk("ps_e6_count", r3, 32'd0);
    rd(A_STATUS); chk("ps_e6_status", r3, 32'd1);
    rd(A_CTRL);   chk("ps_e6_ctrl", r3, 32'd0);
    chk("ps_hwint_ie0", {31'd0, hwint3}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_responder.md
Name: timer_responder

Overview:
- Memory-mapped countdown timer that acts as the responder on the CPU memory interface.
- Decodes the CPU's mem_rd/mem_wr strobes.
- Takes the address from a_bus and write data from b_bus.
- Drives read data onto the shared tri-state result_bus.
- Sources the CPU's hwint input when the timer expires.

Parameters:
BASE_ADDR, 32'hFFFF_FF00, word address of register 0; bits [1:0] must be 0.
PRESCALE, 1, clk cycles per timer tick (1..65535); 1 means a tick on every enabled cycle.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
addr  input  32  word address; connected to a_bus.
wdata  input  32  write data; connected to b_bus.
rdata  output(tri)  32  read data; connected to result_bus; Z unless a read hits.
mem_rd  input  1  read strobe from CPU.
mem_wr  input  1  write strobe from CPU.
hwint  output  1  interrupt request to CPU.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Decode: hit = (addr[31:2] == BASE_ADDR[31:2]); register select = addr[1:0].
- Register map:
  - 0 CTRL: bit0 EN, bit1 RELOAD, bit2 IE; other bits read 0.
  - 1 LOAD: 32-bit reload value.
  - 2 COUNT: 32-bit current count.
  - 3 STATUS: bit0 EXP; write-1-to-clear.
- Reads: combinational.
  - rdata = selected register when mem_rd && hit; else all Z.
  - Returns register state as of the current cycle, i.e. pre-edge values.
  - No side effects.
- Writes: captured at posedge when mem_wr && hit.
  - CTRL/LOAD/COUNT are written with wdata.
  - STATUS write clears EXP where wdata[0]=1.
- mem_rd && mem_wr together: the write is performed and the read is still driven with pre-edge data.
- Non-hit accesses: ignored; rdata stays Z.
- Prescaler: counter psc counts 0..PRESCALE-1 while EN=1.
  - tick = EN && (psc == PRESCALE-1).
  - psc resets to 0 on tick, when EN=0, and on any CTRL write.
- Count on tick:
  - COUNT > 1: COUNT <= COUNT-1.
  - COUNT == 1: EXP <= 1.
    - RELOAD=1: COUNT <= LOAD, so the period is LOAD ticks.
    - RELOAD=0: COUNT <= 0 and EN <= 0 (one-shot).
  - COUNT == 0: no change, no expiry.
- Simultaneous events:
  - A CPU write to COUNT overrides the decrement/reload in that cycle; no expiry is taken that cycle.
  - A CPU write to CTRL overrides the hardware clear of EN.
  - Expiry and a STATUS clear in the same cycle: EXP ends as 1 (set wins).
  - A LOAD write and a reload in the same cycle: COUNT takes the new wdata.
- hwint: registered-equivalent; hwint = EXP && IE, with both from flops so there is no combinational path from the bus. It stays high until EXP is cleared or IE is dropped.
- Reset (async, any time including mid-count): CTRL=0, LOAD=0, COUNT=0, EXP=0, psc=0, hwint=0, rdata=Z.

Test Plan:
- Reset/idle:
  - Assert rst mid-count (COUNT=5, EN=1) → all registers read 0, hwint=0.
  - Read at addr 32'h0000_0010 → rdata Z.
- One-shot (PRESCALE=1):
  - Write COUNT=3, then CTRL=32'h5 → EXP=1 and hwint=1 three cycles after the CTRL write edge.
  - COUNT reads 0, CTRL reads 32'h4.
  - Write STATUS=1 → hwint=0 next cycle.
- Auto-reload:
  - Write LOAD=4, COUNT=4, CTRL=32'h7 → EXP sets every 4 cycles.
  - COUNT sequence 4,3,2,1,4,3,...
  - Clearing EXP between expiries re-raises hwint exactly at the next expiry.
- Prescaler (PRESCALE=3):
  - COUNT=2, CTRL=32'h1 → COUNT decrements on cycles 3 and 6; EXP set at cycle 6.
  - IE=0, so hwint stays 0 while EXP reads 1.
- Collisions:
  - STATUS clear on the expiry cycle → EXP stays 1.
  - Write COUNT=9 on the cycle COUNT would hit 0 → COUNT=9, EXP unchanged.
- Read/write same cycle: mem_rd=mem_wr=1 at offset 1 with wdata=32'hAB, LOAD previously 7 → rdata=7 that cycle; LOAD reads 32'hAB afterwards.
